// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    HALTED  = 2'd2,
    TRAPPED = 2'd3
  } pc_seq_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  // Number of always-zero low PC bits for a given instruction size.
  function automatic int unsigned align_bits(input int unsigned inst_bytes);
    return $clog2(inst_bytes);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Fetch handshake plus execute redirect channel of the PC sequencer.
interface pc_seq_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned EPOCH_BITS = 2
);
  logic [XLEN-1:0]       pc;
  logic                  pc_valid;
  logic                  pc_ready;
  logic [EPOCH_BITS-1:0] epoch;
  logic                  flush;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_target;

  modport master (
    output pc, pc_valid, epoch, flush,
    input  pc_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  pc, pc_valid, epoch, flush,
    output pc_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/pc_seq_target_check.sv
// Redirect target alignment check and low-bit masking.
// PC_SEQ_MISALIGN_TRAP_EN: report misaligned targets instead of silently aligning them.
module pc_seq_target_check
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic [XLEN-1:0] target,
  output logic            aligned,
  output logic [XLEN-1:0] masked_target
);

  localparam int unsigned     ALIGN_BITS = align_bits(INST_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK   = ~({XLEN{1'b1}} << ALIGN_BITS);

  assign masked_target = target & ~LOW_MASK;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign aligned = ((target & LOW_MASK) == '0);
`else
  assign aligned = 1'b1;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch address issue, redirect/flush/epoch, halt and trap.
// Misaligned-target trapping is enabled by PC_SEQ_MISALIGN_TRAP_EN (see pc_seq_target_check).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     INST_BYTES   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned     EPOCH_BITS   = 2
) (
  input  logic            clock,
  input  logic            reset,
  pc_seq_if.master        bus,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  input  logic            trap_clear
);

  pc_seq_state_e         state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
  logic [XLEN-1:0]       trap_pc_q, trap_pc_d;
  logic                  flush_q, flush_d;
  logic                  pc_valid_q, halted_q, trap_q;
  logic                  aligned;
  logic [XLEN-1:0]       masked_target;

  pc_seq_target_check #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_target_check (
    .target        (bus.redirect_target),
    .aligned       (aligned),
    .masked_target (masked_target)
  );

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epoch_d   = epoch_q;
    trap_pc_d = trap_pc_q;
    flush_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        // Redirects win over a same-cycle handshake: the accepted pc is already stale.
        if (bus.redirect_valid && !aligned) begin
          state_d   = TRAPPED;
          trap_pc_d = bus.redirect_target;
          epoch_d   = epoch_q + EPOCH_BITS'(1);
          flush_d   = 1'b1;
        end else if (bus.redirect_valid) begin
          state_d = FLUSH;
          pc_d    = masked_target;
          epoch_d = epoch_q + EPOCH_BITS'(1);
          flush_d = 1'b1;
        end else if (halt_req) begin
          state_d = HALTED;
        end else if (bus.pc_ready) begin
          pc_d = pc_q + XLEN'(INST_BYTES);
        end
      end
      FLUSH: begin
        state_d = halt_req ? HALTED : RUN;
      end
      HALTED: begin
        if (bus.redirect_valid) begin
          pc_d    = masked_target;
          epoch_d = epoch_q + EPOCH_BITS'(1);
          flush_d = 1'b1;
        end
        if (resume && !halt_req) begin
          state_d = RUN;
        end
      end
      TRAPPED: begin
        if (trap_clear) begin
          state_d   = RUN;
          pc_d      = TRAP_VECTOR;
          epoch_d   = epoch_q + EPOCH_BITS'(1);
          trap_pc_d = '0;
          flush_d   = 1'b1;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset is synchronous; it only takes effect on a clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FLUSH;
      pc_q       <= RESET_VECTOR;
      epoch_q    <= '0;
      trap_pc_q  <= '0;
      flush_q    <= 1'b0;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      trap_pc_q  <= trap_pc_d;
      flush_q    <= flush_d;
      pc_valid_q <= (state_d == RUN);
      halted_q   <= (state_d == HALTED);
      trap_q     <= (state_d == TRAPPED);
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.epoch    = epoch_q;
  assign bus.flush    = flush_q;
  assign halted       = halted_q;
  assign trap         = trap_q;
  assign trap_pc      = trap_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (default vectors plus a high RESET_VECTOR wrap instance).
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halt_req, resume, trap_clear;
  logic        halted, trap;
  logic [31:0] trap_pc;
  logic        halted1, trap1;
  logic [31:0] trap_pc1;
  logic [1:0]  ep;

  pc_seq_if #(.XLEN(32), .EPOCH_BITS(2)) f0 ();
  pc_seq_if #(.XLEN(32), .EPOCH_BITS(2)) f1 ();

  pc_sequencer #(
    .XLEN(32), .INST_BYTES(4), .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR(32'h0000_0100), .EPOCH_BITS(2)
  ) dut0 (
    .clock(clock), .reset(reset), .bus(f0.master),
    .halt_req(halt_req), .resume(resume), .halted(halted),
    .trap(trap), .trap_pc(trap_pc), .trap_clear(trap_clear)
  );

  pc_sequencer #(
    .XLEN(32), .INST_BYTES(4), .RESET_VECTOR(32'hFFFF_FFF8),
    .TRAP_VECTOR(32'h0000_0100), .EPOCH_BITS(2)
  ) dut1 (
    .clock(clock), .reset(reset), .bus(f1.master),
    .halt_req(1'b0), .resume(1'b0), .halted(halted1),
    .trap(trap1), .trap_pc(trap_pc1), .trap_clear(1'b0)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [1:0]  epoch;
    logic        halted;
    logic        trap;
    logic [31:0] trap_pc;
  } snap_t;

  snap_t q0[$];
  snap_t q1[$];
  string t0[$];
  string t1[$];
  int    compared   = 0;
  int    mismatched = 0;

  function automatic snap_t mk(logic [31:0] pc, logic v, logic f, logic [1:0] e,
                               logic h, logic t, logic [31:0] tpc);
    snap_t s;
    s.pc = pc; s.pc_valid = v; s.flush = f; s.epoch = e;
    s.halted = h; s.trap = t; s.trap_pc = tpc;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("pc=%h valid=%b flush=%b epoch=%0d halted=%b trap=%b trap_pc=%h",
                     s.pc, s.pc_valid, s.flush, s.epoch, s.halted, s.trap, s.trap_pc);
  endfunction

  function automatic snap_t snap0();
    return mk(f0.pc, f0.pc_valid, f0.flush, f0.epoch, halted, trap, trap_pc);
  endfunction

  function automatic snap_t snap1();
    return mk(f1.pc, f1.pc_valid, f1.flush, f1.epoch, halted1, trap1, trap_pc1);
  endfunction

  task automatic exp0(string tag, logic [31:0] pc, logic v, logic f, logic [1:0] e,
                      logic h, logic t, logic [31:0] tpc);
    q0.push_back(mk(pc, v, f, e, h, t, tpc));
    t0.push_back(tag);
  endtask

  task automatic exp1(string tag, logic [31:0] pc, logic v);
    q1.push_back(mk(pc, v, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0));
    t1.push_back(tag);
  endtask

  task automatic check(string tag, snap_t obs, snap_t want);
    compared++;
    assert (obs === want)
    else begin
      mismatched++;
      $error("FAIL %s: observed {%s} expected {%s}", tag, fmt(obs), fmt(want));
    end
  endtask

  // One clock: sample #1 after the edge and retire the expectations pushed for it.
  task automatic tick();
    @(posedge clock);
    #1;
    if (q0.size() != 0) check(t0.pop_front(), snap0(), q0.pop_front());
    if (q1.size() != 0) check(t1.pop_front(), snap1(), q1.pop_front());
  endtask

  task automatic drive(logic rdy, logic rv, logic [31:0] tgt, logic hr, logic rs, logic tc);
    f0.pc_ready        = rdy;
    f0.redirect_valid  = rv;
    f0.redirect_target = tgt;
    halt_req           = hr;
    resume             = rs;
    trap_clear         = tc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    f1.pc_ready        = 1'b0;
    f1.redirect_valid  = 1'b0;
    f1.redirect_target = 32'h0;
    drive(0, 0, 32'h0, 0, 0, 0);

    reset = 1'b1;
    exp0("reset", 32'h0, 0, 0, 2'd0, 0, 0, 32'h0);
    exp1("rv_reset", 32'hFFFF_FFF8, 0);
    tick();

    reset = 1'b0;
    f0.pc_ready = 1'b1;
    f1.pc_ready = 1'b1;
    exp0("boot_valid", 32'h0, 1, 0, 2'd0, 0, 0, 32'h0);
    exp1("rv_boot", 32'hFFFF_FFF8, 1);
    tick();
    exp0("adv_4", 32'h4, 1, 0, 2'd0, 0, 0, 32'h0);
    exp1("rv_fffc", 32'hFFFF_FFFC, 1);
    tick();
    exp0("adv_8", 32'h8, 1, 0, 2'd0, 0, 0, 32'h0);
    exp1("rv_wrap", 32'h0, 1);
    tick();
    f1.pc_ready = 1'b0;
    exp0("adv_c", 32'hC, 1, 0, 2'd0, 0, 0, 32'h0);
    tick();

    drive(1, 1, 32'h40, 0, 0, 0);
    exp0("redir_flush", 32'h40, 0, 1, 2'd1, 0, 0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 0, 0, 0);
    exp0("redir_valid", 32'h40, 1, 0, 2'd1, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    exp0("redir_hold", 32'h40, 1, 0, 2'd1, 0, 0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 0, 0, 0);
    exp0("adv_44", 32'h44, 1, 0, 2'd1, 0, 0, 32'h0);
    tick();

    drive(0, 0, 32'h0, 1, 0, 0);
    exp0("halt_enter", 32'h44, 0, 0, 2'd1, 1, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    exp0("halt_hold", 32'h44, 0, 0, 2'd1, 1, 0, 32'h0);
    tick();
    drive(0, 1, 32'h80, 0, 0, 0);
    exp0("halt_redir", 32'h80, 0, 1, 2'd2, 1, 0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 0, 0, 0);
    exp0("halt_after_redir", 32'h80, 0, 0, 2'd2, 1, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 1, 0);
    exp0("resume_blocked", 32'h80, 0, 0, 2'd2, 1, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 1, 0);
    exp0("resume", 32'h80, 1, 0, 2'd2, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    exp0("resume_idle", 32'h80, 1, 0, 2'd2, 0, 0, 32'h0);
    tick();

    drive(0, 1, 32'h42, 0, 0, 0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    exp0("trap_enter", 32'h80, 0, 1, 2'd3, 0, 1, 32'h42);
    tick();
    drive(1, 1, 32'h200, 1, 1, 0);
    exp0("trap_ignore", 32'h80, 0, 0, 2'd3, 0, 1, 32'h42);
    tick();
    drive(0, 0, 32'h0, 0, 0, 1);
    exp0("trap_clear", 32'h100, 1, 1, 2'd0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    exp0("trap_run", 32'h100, 1, 0, 2'd0, 0, 0, 32'h0);
    tick();
    ep = 2'd0;
`else
    exp0("misalign_masked", 32'h40, 0, 1, 2'd3, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    exp0("misalign_run", 32'h40, 1, 0, 2'd3, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 1);
    exp0("clear_ignored", 32'h40, 1, 0, 2'd3, 0, 0, 32'h0);
    tick();
    ep = 2'd3;
`endif

    ep = ep + 2'd1;
    drive(0, 1, 32'h500, 0, 0, 0);
    exp0("flush_halt_redir", 32'h500, 0, 1, ep, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 0, 0);
    exp0("flush_halt", 32'h500, 0, 0, ep, 1, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 1, 0);
    exp0("flush_halt_resume", 32'h500, 1, 0, ep, 0, 0, 32'h0);
    tick();

    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 0);
    exp0("reset2", 32'h0, 0, 0, 2'd0, 0, 0, 32'h0);
    tick();
    reset = 1'b0;
    exp0("reset2_boot", 32'h0, 1, 0, 2'd0, 0, 0, 32'h0);
    tick();

    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 32'(i) << 12, 0, 0, 0);
      exp0($sformatf("epoch_redir_%0d", i), 32'(i) << 12, 0, 1, 2'(i), 0, 0, 32'h0);
      tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      exp0($sformatf("epoch_run_%0d", i), 32'(i) << 12, 1, 0, 2'(i), 0, 0, 32'h0);
      tick();
    end

    drive(0, 1, 32'h600, 0, 0, 0);
    exp0("pre_reset_flush", 32'h600, 0, 1, 2'd1, 0, 0, 32'h0);
    tick();
    reset = 1'b1;
    drive(1, 1, 32'h700, 1, 1, 1);
    exp0("reset_mid_flush", 32'h0, 0, 0, 2'd0, 0, 0, 32'h0);
    tick();
    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 0);
    exp0("post_reset_boot", 32'h0, 1, 0, 2'd0, 0, 0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
